// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared constants, FSM state type and zigzag table for the JPEG entropy front end
//   DATA_WIDTH/FRAC_BITS : Q16.16 coefficient format
//   VAL_WIDTH/SAT_LIMIT  : signed output amplitude width and symmetric clamp
//   ZRL_RUN/EOB_RUN      : run field of the zero-run-length and end-of-block symbols
//   ZIGZAG               : zigzag scan index -> raster index
package jpeg_pkg;
    localparam int DATA_WIDTH  = 32;
    localparam int FRAC_BITS   = 16;
    localparam int VAL_WIDTH   = 12;
    localparam int SAT_LIMIT   = 2047;
    localparam int PIXEL_COUNT = 64;
    localparam logic [3:0] ZRL_RUN = 4'd15;
    localparam logic [3:0] EOB_RUN = 4'd0;
    typedef enum logic [1:0] {IDLE, SCAN, EOB} state_t;
    localparam logic [5:0] ZIGZAG [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };
endpackage

// File: rtl/q16_round_sat.sv
// q16_round_sat: round a Q16.16 value half toward +inf and clamp to +/-SAT_LIMIT
//   x : signed fixed-point coefficient
//   y : signed integer amplitude
module q16_round_sat #(
    parameter int DATA_WIDTH = jpeg_pkg::DATA_WIDTH,
    parameter int FRAC_BITS  = jpeg_pkg::FRAC_BITS,
    parameter int VAL_WIDTH  = jpeg_pkg::VAL_WIDTH,
    parameter int SAT_LIMIT  = jpeg_pkg::SAT_LIMIT
) (
    input  logic [DATA_WIDTH-1:0] x,
    output logic [VAL_WIDTH-1:0]  y
);
    localparam int IW = DATA_WIDTH - FRAC_BITS + 1;
    localparam logic signed [IW-1:0] HI = IW'(SAT_LIMIT);
    localparam logic signed [IW-1:0] LO = -HI;
    localparam logic [DATA_WIDTH:0] HALF = {{(DATA_WIDTH-FRAC_BITS+1){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
    logic signed [IW-1:0] ip;
    always_comb begin
        // one extra bit of headroom so +0.5 cannot wrap the most positive input
        ip = IW'(({x[DATA_WIDTH-1], x} + HALF) >> FRAC_BITS);
        y = ip > HI ? HI[VAL_WIDTH-1:0] : ip < LO ? LO[VAL_WIDTH-1:0] : ip[VAL_WIDTH-1:0];
    end
endmodule

// File: rtl/zigzag_rle.sv
// zigzag_rle: zigzag-scan a quantized 8x8 block and emit JPEG (run, amplitude) symbols
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid, in_ready   : block handshake for q_block (raster order, Q16.16)
//   out_valid, out_ready : symbol handshake
//   out_run, out_value   : zeros preceding the amplitude, signed amplitude
//   out_eob              : end-of-block symbol
module zigzag_rle #(
    parameter int DATA_WIDTH  = jpeg_pkg::DATA_WIDTH,
    parameter int PIXEL_COUNT = jpeg_pkg::PIXEL_COUNT,
    parameter int VAL_WIDTH   = jpeg_pkg::VAL_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] q_block,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [3:0]                        out_run,
    output logic [VAL_WIDTH-1:0]              out_value,
    output logic                              out_eob
);
    import jpeg_pkg::*;
    localparam int KW = $clog2(PIXEL_COUNT);
    localparam logic [KW-1:0] K_LAST = KW'(PIXEL_COUNT - 1);
    state_t state;
    logic [DATA_WIDTH*PIXEL_COUNT-1:0] blk;
    logic [KW-1:0] k, last_nz, lnz;
    logic [3:0] run;
    logic none, scan, emit, cur_nz;
    logic [PIXEL_COUNT-1:0] nz;
    logic [VAL_WIDTH-1:0] pre [PIXEL_COUNT];
    logic [VAL_WIDTH-1:0] cur;
    // converted view of the incoming block, only needed to find last_nz at capture
    for (genvar i = 0; i < PIXEL_COUNT; i++) begin : g_pre
        q16_round_sat #(.DATA_WIDTH(DATA_WIDTH), .VAL_WIDTH(VAL_WIDTH)) u_pre (
            .x(q_block[i*DATA_WIDTH +: DATA_WIDTH]),
            .y(pre[i])
        );
        assign nz[i] = |pre[i];
    end
    always_comb begin
        lnz = '0;
        for (int z = 0; z < PIXEL_COUNT; z++)
            lnz = nz[ZIGZAG[z]] ? KW'(z) : lnz;
    end
    q16_round_sat #(.DATA_WIDTH(DATA_WIDTH), .VAL_WIDTH(VAL_WIDTH)) u_cur (
        .x(blk[ZIGZAG[k]*DATA_WIDTH +: DATA_WIDTH]),
        .y(cur)
    );
    // symbols are presented straight from the scan position so the first one
    // appears the cycle after capture and zeros are skipped at one per cycle
    always_comb begin
        scan = state == SCAN;
        cur_nz = |cur;
        out_eob = state == EOB || (scan && none);
        emit = scan && !none && (cur_nz || run == ZRL_RUN);
        out_valid = out_eob || emit;
        out_run = emit ? run : EOB_RUN;
        out_value = emit ? cur : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            in_ready <= 1'b0;
            k <= '0;
            run <= '0;
            last_nz <= '0;
            none <= 1'b0;
            blk <= '0;
        end else begin
            case (state)
                IDLE:
                    if (in_valid && in_ready) begin
                        blk <= q_block;
                        last_nz <= lnz;
                        none <= ~|nz;
                        k <= '0;
                        run <= '0;
                        in_ready <= 1'b0;
                        state <= SCAN;
                    end else
                        in_ready <= 1'b1;
                SCAN:
                    if (out_eob) begin
                        if (out_ready) begin
                            state <= IDLE;
                            in_ready <= 1'b1;
                        end
                    end else if (emit) begin
                        if (out_ready) begin
                            run <= '0;
                            // the last nonzero ends the scan; a full block needs no EOB
                            if (k == last_nz) begin
                                state <= k == K_LAST ? IDLE : EOB;
                                in_ready <= k == K_LAST;
                            end else
                                k <= k + 1'b1;
                        end
                    end else begin
                        run <= run + 1'b1;
                        k <= k + 1'b1;
                    end
                EOB:
                    if (out_ready) begin
                        state <= IDLE;
                        in_ready <= 1'b1;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_zigzag_rle.sv
// tb_zigzag_rle: scoreboard bench for zigzag_rle against a block-level symbol model
module tb_zigzag_rle;
    typedef struct packed {logic [3:0] run; logic [11:0] value; logic eob;} sym_t;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, out_eob;
    logic [2047:0] q_block = '0;
    logic [3:0] out_run;
    logic [11:0] out_value;
    int compared = 0, mismatched = 0, ready_mode = 0;
    sym_t exp_q[$];
    int zz[64];
    logic [31:0] coef[64];
    logic pend = 1'b0;
    sym_t held, got;

    zigzag_rle dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .q_block(q_block),
        .out_valid(out_valid), .out_ready(out_ready), .out_run(out_run), .out_value(out_value),
        .out_eob(out_eob)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] actual, logic [31:0] want);
        compared++;
        if (actual !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, want);
        end
    endtask

    function automatic sym_t mk(int r, int v, bit e);
        return '{4'(r), 12'(v), e};
    endfunction

    function automatic int conv(logic [31:0] x);
        longint v;
        v = (longint'(signed'(x)) + 64'sd32768) >>> 16;
        return v > 2047 ? 2047 : v < -2047 ? -2047 : int'(v);
    endfunction

    // zigzag order from walking the anti-diagonals of the 8x8 grid
    task automatic build_zz();
        int n, lo, hi, r;
        n = 0;
        for (int s = 0; s < 15; s++) begin
            lo = s > 7 ? s - 7 : 0;
            hi = s < 7 ? s : 7;
            for (int j = 0; j <= hi - lo; j++) begin
                r = (s % 2 == 1) ? lo + j : hi - j;
                zz[n] = r * 8 + (s - r);
                n++;
            end
        end
    endtask

    // each nonzero carries the zeros before it: one ZRL per full 16, remainder as run
    task automatic model(output bit imm);
        int vals[64];
        int last, zeros;
        last = -1;
        zeros = 0;
        for (int z = 0; z < 64; z++) begin
            vals[z] = conv(coef[zz[z]]);
            if (vals[z] != 0) last = z;
        end
        imm = last < 0 || vals[0] != 0;
        if (last < 0) exp_q.push_back(mk(0, 0, 1));
        else begin
            for (int z = 0; z <= last; z++) begin
                if (vals[z] == 0) zeros++;
                else begin
                    repeat (zeros / 16) exp_q.push_back(mk(15, 0, 0));
                    exp_q.push_back(mk(zeros % 16, vals[z], 0));
                    zeros = 0;
                end
            end
            if (last < 63) exp_q.push_back(mk(0, 0, 1));
        end
    endtask

    task automatic clear();
        for (int i = 0; i < 64; i++) coef[i] = '0;
    endtask

    task automatic rand_block();
        int tail, r;
        tail = $urandom % 64;
        for (int i = 0; i < 64; i++) begin
            r = $urandom % 10;
            coef[i] = r < 5 ? 32'h0 : r == 5 ? 32'h00007FFF : r == 6 ? 32'hFFFF8000 :
                      r == 7 ? $urandom : r == 8 ? ((32'($urandom_range(0, 100)) - 32'd50) << 16) | 32'($urandom_range(0, 65535)) :
                      32'h00018000;
        end
        for (int z = tail + 1; z < 64; z++) coef[zz[z]] = '0;
        if ($urandom % 8 == 0) clear();
    endtask

    task automatic send();
        bit imm;
        int n;
        n = 0;
        @(negedge clk);
        for (int i = 0; i < 64; i++) q_block[i*32 +: 32] = coef[i];
        in_valid = 1'b1;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
            in_valid = 1'b0;
            return;
        end
        model(imm);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("first_valid", 32'(out_valid), 32'(imm));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 0);
        check("drain_ready", 32'(in_ready), 1);
    endtask

    initial forever begin
        @(posedge clk);
        #1 out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ($urandom % 4 != 0) : 1'b0;
    end

    always @(negedge clk) begin
        got = '{out_run, out_value, out_eob};
        if (!rst_n) pend = 1'b0;
        else begin
            if (pend) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_symbol", 32'(got), 32'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_symbol: got %0h, expected none", got);
                end else
                    check("symbol", 32'(got), 32'(exp_q.pop_front()));
            end
            pend = out_valid && !out_ready;
            held = got;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        build_zz();
        #12;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_run", 32'(out_run), 0);
        check("rst_out_value", 32'(out_value), 0);
        check("rst_out_eob", 32'(out_eob), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        check("release_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1 check("first_edge_in_ready", 32'(in_ready), 1);
        ready_mode = 0;
        clear();
        send();
        drain();
        clear();
        coef[0] = 32'h000A0000;
        send();
        drain();
        clear();
        coef[1] = 32'h00030000;
        coef[8] = 32'hFFFE0000;
        send();
        drain();
        clear();
        coef[63] = 32'h00018000;
        send();
        drain();
        clear();
        coef[0] = 32'h7FFF0000;
        coef[1] = 32'h80000000;
        send();
        drain();
        clear();
        coef[0] = 32'hFFFE8000;
        send();
        drain();
        clear();
        for (int i = 0; i < 6; i++) coef[i] = 32'(i + 1) << 16;
        send();
        repeat (2) @(negedge clk);
        ready_mode = 2;
        repeat (5) @(negedge clk);
        ready_mode = 0;
        drain();
        ready_mode = 1;
        for (int b = 0; b < 40; b++) begin
            rand_block();
            send();
        end
        drain();
        for (int i = 0; i < 64; i++) coef[i] = 32'((i % 7) + 1) << 16;
        send();
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("midscan_out_valid", 32'(out_valid), 0);
        check("midscan_in_ready", 32'(in_ready), 0);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        check("midscan_release_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1 check("midscan_ready_rise", 32'(in_ready), 1);
        check("midscan_no_eob", 32'(out_valid), 0);
        rand_block();
        send();
        drain();
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/zigzag_rle.md
ZIGZAG_RLE -- requirements
Module: zigzag_rle

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning Q16.16 coefficient width.
REQ-002 SHALL have parameter PIXEL_COUNT, default 64, meaning coefficients per 8x8 block.
REQ-003 SHALL have parameter VAL_WIDTH, default 12, meaning signed output amplitude width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: q_block holds a valid block.
REQ-007 SHALL have port in_ready, output, 1 bit: block can be accepted.
REQ-008 SHALL have port q_block, input, DATA_WIDTH*PIXEL_COUNT bits: quantizer output, raster order, coefficient i at bits [i*32 +: 32], Q16.16 signed.
REQ-009 SHALL have port out_valid, output, 1 bit: output symbol valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the symbol.
REQ-011 SHALL have port out_run, output, 4 bits: zeros preceding out_value.
REQ-012 SHALL have port out_value, output, VAL_WIDTH bits: signed amplitude.
REQ-013 SHALL have port out_eob, output, 1 bit: end-of-block symbol.

Function
REQ-014 SHALL capture q_block into an internal register on the cycle in_valid&&in_ready; in_ready SHALL be high only in state IDLE.
REQ-015 SHALL convert each coefficient as (x + 0x8000) >>> 16 (round half toward +inf), saturated to [-2047, +2047].
REQ-016 SHALL compute last_nz, the highest zigzag index with a nonzero converted value, at capture; an all-zero block SHALL be flagged as none.
REQ-017 SHALL use FSM states IDLE -> SCAN -> (EOB | IDLE) -> IDLE; capture moves IDLE to SCAN with scan index k=0 and run=0.
REQ-018 In SCAN, each advance of k SHALL examine the coefficient at zigzag position k (standard JPEG zigzag table).
REQ-019 Zero coefficient with run<15: run+1, no symbol emitted, k advances the same cycle.
REQ-020 Zero coefficient with run==15: emit ZRL (run=15, value=0, eob=0), then run=0.
REQ-021 Nonzero coefficient: emit (run, value, eob=0), then run=0.
REQ-022 When k > last_nz or the block is all-zero: emit a single EOB (run=0, value=0, eob=1), then go to IDLE.
REQ-023 When last_nz==63: no EOB; go to IDLE after the k=63 symbol is accepted.
REQ-024 A symbol is accepted on out_valid&&out_ready; while out_valid&&!out_ready, out_run/out_value/out_eob/k SHALL hold stable.
REQ-025 The first symbol SHALL be valid on the first cycle after capture; with out_ready held high, one coefficient SHALL be consumed per cycle.

Reset
REQ-026 While rst_n is low: state=IDLE, in_ready=0, out_valid=0, out_run=0, out_value=0, out_eob=0, k=0, run=0, all taking effect immediately.
REQ-027 in_ready SHALL rise on the first clock edge after rst_n deasserts; reset mid-scan SHALL discard the block with no partial EOB.

Structure
REQ-028 Shared package jpeg_pkg SHALL hold DATA_WIDTH, FRAC_BITS=16, VAL_WIDTH, the saturation limit 2047, the ZRL/EOB encodings and the 64-entry zigzag-to-raster table.
REQ-029 The design SHALL contain one sub-module, q16_round_sat: combinational round and saturate, instanced per coefficient read.

Verification
REQ-030 All-zero block, out_ready=1 -> single symbol (0,0,eob=1) one cycle after accept, then in_ready=1.
REQ-031 Raster[0]=0x000A0000, rest 0 -> (0,10) then EOB.
REQ-032 Raster[1]=0x00030000, raster[8]=0xFFFE0000, rest 0 -> (1,3), (0,-2), EOB.
REQ-033 Only raster[63]=0x00018000 -> three ZRL (15,0) then (15,2), no EOB.
REQ-034 Raster[0]=0x7FFF0000, raster[1]=0x80000000 -> (0,2047), (0,-2047), EOB; raster[0]=0xFFFE8000 -> (0,-1).
REQ-035 Backpressure: out_ready low 5 cycles mid-stream -> symbol held stable and no symbol lost; rst_n pulsed low mid-scan -> out_valid=0 immediately and in_ready=1 one cycle after release.
